fxp_addsub_arbiter: RTL and testbench
=====================================

# fxp_addsub_arbiter

Round-robin arbiter and sequencer that shares one pipelined fixed-point add/sub datapath (FixedPointAddSub-class unit, fixed latency) between NUM_REQ requesters. It accepts at most one operation per cycle via valid/ready handshakes and issues it to the datapath. It tracks the requester ID of each in-flight operation internally, so the datapath needs no tags. Each result is routed back to its originating requester as a one-cycle response pulse. The block sits between the filter-stage control logic and the shared arithmetic unit.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, operand/result width (fixed-point, format opaque to this block)
- ALU_LAT, 2, datapath latency in cycles from o_alu_valid to i_alu_result (>=1)

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_enable  in  1  1 = grants allowed; 0 = no new grants, in-flight ops complete
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_a  in  NUM_REQ*DATA_W  operand A, requester n at [n*DATA_W +: DATA_W]
- i_req_b  in  NUM_REQ*DATA_W  operand B, same packing
- i_req_sub  in  NUM_REQ  1 = A-B, 0 = A+B
- o_req_ready  out  NUM_REQ  one-hot grant (combinational)
- o_alu_valid  out  1  issue strobe to datapath (registered)
- o_alu_a, o_alu_b  out  DATA_W  issued operands (registered)
- o_alu_sub  out  1  issued op (registered)
- i_alu_result  in  DATA_W  datapath result, valid exactly ALU_LAT cycles after o_alu_valid
- o_rsp_valid  out  NUM_REQ  one-hot response strobe (registered)
- o_rsp_data  out  DATA_W  response result (registered)
- o_busy  out  1  1 while any operation is in flight (issued, response not yet delivered)

## Operation
- Handshake: transfer on requester n when i_req_valid[n] & o_req_ready[n]. The requester holds valid and operands stable until transfer.
- Grant: o_req_ready = 0 when i_enable=0 or i_reset_n=0. Otherwise it is one-hot on the first valid requester found searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0. All zero if no valid.
- rr_ptr: reset 0. On a grant to n, rr_ptr <= (n+1) mod NUM_REQ. It is unchanged without a grant.
- Issue register: on a grant, o_alu_valid<=1 and o_alu_a/b/sub <= granted requester's fields. Otherwise o_alu_valid<=0 and the data holds its last value.
- Tag pipeline: a shift register of ALU_LAT+1 entries {valid, id}. Stage 0 is loaded alongside the issue register. The entry aligned with i_alu_result has valid=1 exactly when the result belongs to a live op.
- Response: when the aligned entry is valid, o_rsp_valid <= onehot(id) and o_rsp_data <= i_alu_result. Otherwise o_rsp_valid <= 0 and o_rsp_data holds.
- No response backpressure: requesters must accept o_rsp_valid when it pulses.
- o_busy = OR of all tag-pipeline valids and o_rsp_valid.
- Results are returned in issue order. The block does no arithmetic; overflow/saturation is the datapath's concern.

## Timing
- Reset (i_reset_n=0 at a rising edge) sets o_alu_valid=0, o_alu_a=o_alu_b=0, o_alu_sub=0, o_rsp_valid=0, o_rsp_data=0 and rr_ptr=0. It clears all tag valids, so o_busy=0.
- Reset mid-operation drops every in-flight op. Datapath results arriving after reset produce no response.
- Latency, with the handshake in cycle 0: o_alu_valid is high in cycle 1, i_alu_result is sampled in cycle 1+ALU_LAT, and o_rsp_valid is high in cycle 2+ALU_LAT (cycle 4 at default).
- Throughput: one grant per cycle sustained, with no bubbles under continuous requests.
- i_enable falling: no grant in that same cycle. Ops already issued complete normally, and rr_ptr is frozen.
- A requester may re-request in the cycle after its transfer. It is then served after the other pending requesters, per round-robin order.

## Test plan
- Single op: only requester 2 valid, a=0x10, b=0x05, sub=0 in cycle 0 -> o_req_ready=4'b0100 in cycle 0; o_alu_valid=1, a=0x10, b=0x05, sub=0 in cycle 1; model returns 0x15 in cycle 3; o_rsp_valid=4'b0100, o_rsp_data=0x15 in cycle 4, then 0; o_busy high in cycles 1-4.
- Fairness: all four valid continuously from reset -> grant order 0,1,2,3,0,1,...; o_alu_valid high every cycle from cycle 1; responses in the same order ALU_LAT+1 cycles behind.
- Wrap: rr_ptr=2 (after a grant to 1), requesters 1 and 3 valid -> grant 3, then 1; rr_ptr ends at 2.
- Enable gating: i_enable=0 for 3 cycles with all requesters valid and one op in flight -> o_req_ready=0, o_alu_valid=0 during the gap; the in-flight response is still delivered; grants resume at the preserved rr_ptr.
- Reset mid-flight: requester 0 issues sub 0x20-0x08; i_reset_n=0 in cycle 2 for one cycle -> no o_rsp_valid, even though the model drives 0x18 in cycle 3; o_busy=0 and o_alu_valid=0 after reset.
- Ordering: requesters 0 and 1 back-to-back with distinct operands (0x7F+0x01, 0x40-0x41) -> responses in consecutive cycles with matching one-hot IDs and the model's results.

Source files
------------

// File: rtl/fxp_addsub_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency add/sub datapath among
// NUM_REQ requesters and routes each result back to its originator by tag.
module fxp_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  input  logic [NUM_REQ-1:0]        i_req_sub,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_alu_valid,
  output logic [DATA_W-1:0]         o_alu_a,
  output logic [DATA_W-1:0]         o_alu_b,
  output logic                      o_alu_sub,
  input  logic [DATA_W-1:0]         i_alu_result,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAG_N = ALU_LAT + 1;
  localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

  logic [DATA_W-1:0] req_a_arr [NUM_REQ];
  logic [DATA_W-1:0] req_b_arr [NUM_REQ];
  logic [ID_W-1:0]   rot_idx   [NUM_REQ];

  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   rr_ptr_next;
  logic              found;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;

  logic              alu_valid_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic              alu_sub_reg;

  logic [TAG_N-1:0]            tag_valid_reg;
  logic [TAG_N-1:0][ID_W-1:0]  tag_id_reg;

  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [DATA_W-1:0]  rsp_data_reg;

  // rot_idx[k] is the requester visited k-th when searching from rr_ptr.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_a_arr[gi] = i_req_a[gi*DATA_W +: DATA_W];
      assign req_b_arr[gi] = i_req_b[gi*DATA_W +: DATA_W];
      assign rot_idx[gi]   = ID_W'((int'(rr_ptr_reg) + gi) % NUM_REQ);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[rot_idx[k]]) begin
        found    = 1'b1;
        grant_id = rot_idx[k];
      end
    end
  end

  assign grant_any   = found & i_enable & i_reset_n;
  assign o_req_ready = grant_any ? (REQ_ONE << grant_id) : '0;
  assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rr_ptr_reg    <= '0;
      alu_valid_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_sub_reg   <= 1'b0;
      tag_valid_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      alu_valid_reg <= grant_any;
      if (grant_any) begin
        alu_a_reg   <= req_a_arr[grant_id];
        alu_b_reg   <= req_b_arr[grant_id];
        alu_sub_reg <= i_req_sub[grant_id];
        rr_ptr_reg  <= rr_ptr_next;
      end
      tag_valid_reg <= {tag_valid_reg[TAG_N-2:0], grant_any};
      // The oldest tag stage lines up with the datapath result this cycle.
      if (tag_valid_reg[ALU_LAT]) begin
        rsp_valid_reg <= REQ_ONE << tag_id_reg[ALU_LAT];
        rsp_data_reg  <= i_alu_result;
      end else begin
        rsp_valid_reg <= '0;
      end
    end
  end

  // IDs are only meaningful where the matching valid bit is set.
  always_ff @(posedge i_clk) begin
    tag_id_reg <= {tag_id_reg[TAG_N-2:0], grant_id};
  end

  assign o_alu_valid = alu_valid_reg;
  assign o_alu_a     = alu_a_reg;
  assign o_alu_b     = alu_b_reg;
  assign o_alu_sub   = alu_sub_reg;
  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_data  = rsp_data_reg;
  assign o_busy      = (|tag_valid_reg) | (|rsp_valid_reg);

endmodule

// File: tb/tb_fxp_addsub_arbiter.sv
// Self-checking bench: requester/datapath models plus a queue-based reference
// of grants and responses, compared against the full DUT output vector.
module tb_fxp_addsub_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;
  localparam int VW  = 3*W + 2*N + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, en;
  logic [N-1:0]   req_valid, req_sub;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic           alu_valid, alu_sub, busy;
  logic [W-1:0]   alu_a, alu_b, alu_result, rsp_data;

  fxp_addsub_arbiter #(.NUM_REQ(N), .DATA_W(W), .ALU_LAT(LAT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
    .o_req_ready(req_ready), .o_alu_valid(alu_valid), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_sub(alu_sub), .i_alu_result(alu_result), .o_rsp_valid(rsp_valid),
    .o_rsp_data(rsp_data), .o_busy(busy)
  );

  // Datapath model: untagged fixed-latency add/sub.
  logic [W-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= alu_sub ? alu_a - alu_b : alu_a + alu_b;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign alu_result = dp_pipe[LAT-1];

  logic [VW-1:0] obs;
  assign obs = {req_ready, alu_valid, alu_a, alu_b, alu_sub, rsp_valid, rsp_data, busy};

  // Requester state
  logic         pv [N];
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  logic         ps [N];

  // Reference model
  typedef struct { int due; int id; logic [W-1:0] data; } rsp_t;
  rsp_t         q[$];
  int           m_ptr;
  logic         ex_alu_v, ex_sub;
  logic [W-1:0] ex_a, ex_b, ex_rsp_d;
  logic [N-1:0] ex_rsp_v;
  int           cyc, checks, errors;

  function automatic int model_grant();
    if (!rst_n || !en) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int g;
    logic [N-1:0] rdy;
    logic [N-1:0] one;
    logic bsy;
    one = 1;
    g = model_grant();
    rdy = (g >= 0) ? (one << g) : '0;
    bsy = (q.size() > 0) || (ex_rsp_v != '0);
    return {rdy, ex_alu_v, ex_a, ex_b, ex_sub, ex_rsp_v, ex_rsp_d, bsy};
  endfunction

  task automatic drive();
    for (int n = 0; n < N; n++) begin
      req_valid[n]      = pv[n];
      req_sub[n]        = ps[n];
      req_a[n*W +: W]   = pa[n];
      req_b[n*W +: W]   = pb[n];
    end
  endtask

  task automatic sync();
    drive();
    #2;
  endtask

  task automatic load(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    pv[n] = 1'b1; pa[n] = a; pb[n] = b; ps[n] = s;
  endtask

  task automatic load_rand(input int n);
    load(n, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
  endtask

  // Model the clock edge, then move to the next cycle; granted requesters drop valid.
  task automatic advance();
    int g;
    rsp_t e;
    g = model_grant();
    if (!rst_n) begin
      m_ptr = 0; ex_alu_v = 0; ex_a = '0; ex_b = '0; ex_sub = 0;
      ex_rsp_v = '0; ex_rsp_d = '0;
      q.delete();
    end else begin
      ex_rsp_v = '0;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        ex_rsp_v[q[0].id] = 1'b1;
        ex_rsp_d = q[0].data;
        void'(q.pop_front());
      end
      ex_alu_v = (g >= 0);
      if (g >= 0) begin
        ex_a = pa[g]; ex_b = pb[g]; ex_sub = ps[g];
        e.due = cyc + 2 + LAT; e.id = g;
        e.data = ps[g] ? pa[g] - pb[g] : pa[g] + pb[g];
        q.push_back(e);
        m_ptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) pv[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 0; en = 1;
    for (int n = 0; n < N; n++) pv[n] = 0;
    sync();
    advance();
    rst_n = 1;
    sync();
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1;
    for (int n = 0; n < N; n++) load_rand(n);
    sync();
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000);
    end
    checks++;
    for (int c = 0; c < 2; c++) begin
      advance(); sync();
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
    end
    rst_n = 1;
    for (int n = 0; n < N; n++) pv[n] = 0;
    sync();
  endtask

  task automatic test_single_op();
    do_reset();
    load(2, 8'h10, 8'h05, 1'b0);
    sync();
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0100);
    end
    checks++;
    for (int c = 0; c < 7; c++) begin
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL single_op c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      if (c == 4) begin
        if (rsp_valid !== 4'b0100 || rsp_data !== 8'h15) begin
          errors++; $display("FAIL single_rsp got=%b/%h exp=0100/15", rsp_valid, rsp_data);
        end
        checks++;
      end
      advance(); sync();
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] one;
    one = 1;
    do_reset();
    for (int n = 0; n < N; n++) load_rand(n);
    sync();
    for (int c = 0; c < 16; c++) begin
      if (req_ready !== (one << (c % N))) begin
        errors++; $display("FAIL fair_order c=%0d got=%b exp=%b", c, req_ready, one << (c % N));
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL fairness c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      advance();
      for (int n = 0; n < N; n++) if (!pv[n]) load_rand(n);
      sync();
    end
    for (int n = 0; n < N; n++) pv[n] = 0;
    sync();
    for (int c = 0; c < LAT + 3; c++) begin
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL fair_drain c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      advance(); sync();
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_r [4];
    exp_r[0] = 4'b0010; exp_r[1] = 4'b1000; exp_r[2] = 4'b0010; exp_r[3] = 4'b0100;
    do_reset();
    load_rand(1);
    sync();
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin load_rand(1); load_rand(3); end
      if (c == 3) begin load_rand(1); load_rand(2); load_rand(3); end
      sync();
      if (req_ready !== exp_r[c]) begin
        errors++; $display("FAIL wrap c=%0d got=%b exp=%b", c, req_ready, exp_r[c]);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL wrap_vec c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      advance();
    end
    for (int n = 0; n < N; n++) pv[n] = 0;
    sync();
    for (int c = 0; c < LAT + 3; c++) begin advance(); sync(); end
  endtask

  task automatic test_enable();
    do_reset();
    for (int n = 0; n < N; n++) load_rand(n);
    sync();
    for (int c = 0; c < 10; c++) begin
      en = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      sync();
      if (!en && req_ready !== '0) begin
        errors++; $display("FAIL enable_gate c=%0d got=%b exp=0000", c, req_ready);
      end
      if (!en) checks++;
      if (c == 4 && req_ready !== 4'b0010) begin
        errors++; $display("FAIL enable_resume got=%b exp=0010", req_ready);
      end
      if (c == 4) checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL enable c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      advance();
      for (int n = 0; n < N; n++) if (!pv[n]) load_rand(n);
    end
    for (int n = 0; n < N; n++) pv[n] = 0;
    en = 1;
    sync();
    for (int c = 0; c < LAT + 3; c++) begin advance(); sync(); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(0, 8'h20, 8'h08, 1'b1);
    sync();
    for (int c = 0; c < 7; c++) begin
      rst_n = (c == 2) ? 1'b0 : 1'b1;
      sync();
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      if (c >= 3 && (rsp_valid !== '0 || busy !== 1'b0 || alu_valid !== 1'b0)) begin
        errors++; $display("FAIL reset_mid_drop c=%0d got=%b/%b/%b exp=0000/0/0", c, rsp_valid, busy, alu_valid);
      end
      if (c >= 3) checks++;
      advance();
    end
    rst_n = 1;
    sync();
  endtask

  task automatic test_ordering();
    do_reset();
    load(0, 8'h7F, 8'h01, 1'b0);
    load(1, 8'h40, 8'h41, 1'b1);
    sync();
    for (int c = 0; c < 8; c++) begin
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL ordering c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      if (c == 4 && (rsp_valid !== 4'b0001 || rsp_data !== 8'h80)) begin
        errors++; $display("FAIL order_rsp0 got=%b/%h exp=0001/80", rsp_valid, rsp_data);
      end
      if (c == 5 && (rsp_valid !== 4'b0010 || rsp_data !== 8'hFF)) begin
        errors++; $display("FAIL order_rsp1 got=%b/%h exp=0010/ff", rsp_valid, rsp_data);
      end
      if (c == 4 || c == 5) checks++;
      advance(); sync();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en    = ($urandom_range(7, 0) != 0);
      rst_n = ($urandom_range(60, 0) != 0);
      for (int n = 0; n < N; n++) if (!pv[n] && $urandom_range(1, 0) == 1) load_rand(n);
      sync();
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      checks++;
      advance();
    end
    rst_n = 1; en = 1;
    sync();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; m_ptr = 0;
    ex_alu_v = 0; ex_a = '0; ex_b = '0; ex_sub = 0; ex_rsp_v = '0; ex_rsp_d = '0;
    q.delete();
    rst_n = 0; en = 1;
    for (int n = 0; n < N; n++) begin pv[n] = 0; pa[n] = '0; pb[n] = '0; ps[n] = 0; end
    drive();
    test_reset();
    test_single_op();
    test_fairness();
    test_wrap();
    test_enable();
    test_reset_mid();
    test_ordering();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
